// File: rtl/accel_spi_responder.sv
// ADXL362-style SPI mode-0 slave; miso/write/xact_done act SYNC_STAGES+2 clk after pin edges, no backpressure.
// Optional soft-reset command register 0x1F enabled by defining ACCEL_SOFT_RESET_EN.
module accel_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  PART_ID     = 8'hF2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sck,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  input  logic [11:0] temp_data,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        xact_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_WR, S_ADDR_RD, S_IGNORE, S_WRITE, S_READ
  } state_t;

  logic [SYNC_STAGES-1:0] sckSync, ssSync, mosiSync;
  logic sckLvl, ssLvl, mosiLvl;
  logic sckQ, ssQ;
  logic sckRiseP, sckFallP, ssRiseP, ssFallP, mosiBit;

  state_t      state;
  logic [2:0]  bitCnt;
  logic [6:0]  shiftIn;
  logic [7:0]  addr;
  logic [7:0]  txShift;
  logic        loadPend;
  logic        anyByte;
  logic [11:0] xShadow, yShadow, zShadow, tShadow;
  logic [7:0]  newByte;
  logic [7:0]  readData;

  assign sckLvl  = sckSync[SYNC_STAGES-1];
  assign ssLvl   = ssSync[SYNC_STAGES-1];
  assign mosiLvl = mosiSync[SYNC_STAGES-1];
  assign newByte = {shiftIn, mosiBit};
  assign miso    = txShift[7];

  // ss synchronizer resets high so an idle bus never looks like a select.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sckSync  <= '0;
      ssSync   <= '1;
      mosiSync <= '0;
      sckQ     <= 1'b0;
      ssQ      <= 1'b1;
      sckRiseP <= 1'b0;
      sckFallP <= 1'b0;
      ssRiseP  <= 1'b0;
      ssFallP  <= 1'b0;
      mosiBit  <= 1'b0;
    end else begin
      sckSync  <= {sckSync[SYNC_STAGES-2:0], sck};
      ssSync   <= {ssSync[SYNC_STAGES-2:0], ss};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], mosi};
      sckQ     <= sckLvl;
      ssQ      <= ssLvl;
      sckRiseP <= sckLvl & ~sckQ;
      sckFallP <= ~sckLvl & sckQ;
      ssRiseP  <= ssLvl & ~ssQ;
      ssFallP  <= ~ssLvl & ssQ;
      mosiBit  <= mosiLvl;
    end
  end

  always_comb begin
    readData = 8'h00;
    case (addr)
      8'h00: readData = 8'hAD;
      8'h01: readData = 8'h1D;
      8'h02: readData = PART_ID;
      8'h0E: readData = xShadow[7:0];
      8'h0F: readData = {{4{xShadow[11]}}, xShadow[11:8]};
      8'h10: readData = yShadow[7:0];
      8'h11: readData = {{4{yShadow[11]}}, yShadow[11:8]};
      8'h12: readData = zShadow[7:0];
      8'h13: readData = {{4{zShadow[11]}}, zShadow[11:8]};
      8'h14: readData = tShadow[7:0];
      8'h15: readData = {{4{tShadow[11]}}, tShadow[11:8]};
      8'h2C: readData = filter_ctl;
      8'h2D: readData = power_ctl;
      default: readData = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      bitCnt     <= 3'd0;
      shiftIn    <= 7'd0;
      addr       <= 8'h00;
      txShift    <= 8'h00;
      loadPend   <= 1'b0;
      anyByte    <= 1'b0;
      xShadow    <= 12'd0;
      yShadow    <= 12'd0;
      zShadow    <= 12'd0;
      tShadow    <= 12'd0;
      power_ctl  <= 8'h00;
      filter_ctl <= 8'h13;
      xact_done  <= 1'b0;
    end else begin
      xact_done <= 1'b0;
      // ss edges take priority over any coincident sck edge.
      if (ssRiseP) begin
        state     <= S_IDLE;
        bitCnt    <= 3'd0;
        txShift   <= 8'h00;
        loadPend  <= 1'b0;
        xact_done <= anyByte;
        anyByte   <= 1'b0;
      end else if (ssFallP) begin
        state    <= S_CMD;
        bitCnt   <= 3'd0;
        txShift  <= 8'h00;
        loadPend <= 1'b0;
        anyByte  <= 1'b0;
      end else if (state != S_IDLE) begin
        if (sckRiseP) begin
          shiftIn <= newByte[6:0];
          bitCnt  <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            anyByte <= 1'b1;
            case (state)
              S_CMD: begin
                xShadow <= x_data;
                yShadow <= y_data;
                zShadow <= z_data;
                tShadow <= temp_data;
                case (newByte)
                  8'h0A:   state <= S_ADDR_WR;
                  8'h0B:   state <= S_ADDR_RD;
                  default: state <= S_IGNORE;
                endcase
              end
              S_ADDR_WR: begin
                addr  <= newByte;
                state <= S_WRITE;
              end
              S_ADDR_RD: begin
                addr     <= newByte;
                state    <= S_READ;
                loadPend <= 1'b1;
              end
              S_WRITE: begin
                if (addr == 8'h2D) power_ctl <= newByte;
                else if (addr == 8'h2C) filter_ctl <= newByte;
`ifdef ACCEL_SOFT_RESET_EN
                else if (addr == 8'h1F && newByte == 8'h52) begin
                  power_ctl  <= 8'h00;
                  filter_ctl <= 8'h13;
                end
`endif
                addr <= addr + 8'd1;
              end
              S_READ: begin
                addr     <= addr + 8'd1;
                loadPend <= 1'b1;
              end
              default: ;
            endcase
          end
        end else if (sckFallP && state == S_READ) begin
          if (loadPend) begin
            txShift  <= readData;
            loadPend <= 1'b0;
          end else begin
            txShift <= {txShift[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: SPI mode-0 master tasks, hand-computed expected bytes.
`timescale 1ns/1ps
module tb_accel_spi_responder;

  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] x_data = 12'd0, y_data = 12'd0, z_data = 12'd0, temp_data = 12'd0;
  logic [7:0]  power_ctl, filter_ctl;
  logic        xact_done;

  int testsRun = 0;
  int testsFailed = 0;
  int xactCnt = 0;
  logic [7:0] rxBuf [4];

  accel_spi_responder #(.SYNC_STAGES(2), .PART_ID(8'hF2)) dut (
    .clk(clk), .resetn(resetn), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
    .x_data(x_data), .y_data(y_data), .z_data(z_data), .temp_data(temp_data),
    .power_ctl(power_ctl), .filter_ctl(filter_ctl), .xact_done(xact_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (xact_done) xactCnt++;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spiBits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #HALF;
      rx[i] = miso;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
    spiBits(tx, 8, rx);
  endtask

  task automatic ssLow();
    ss = 1'b0;
    #100;
  endtask

  task automatic ssHigh();
    #100;
    ss = 1'b1;
    #200;
  endtask

  task automatic doRead(input logic [7:0] a, input int n);
    logic [7:0] r;
    ssLow();
    spiByte(8'h0B, r);
    spiByte(a, r);
    for (int i = 0; i < n; i++) begin
      spiByte(8'h00, r);
      rxBuf[i] = r;
    end
    ssHigh();
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    ssLow();
    spiByte(8'h0A, r);
    spiByte(a, r);
    spiByte(d, r);
    ssHigh();
  endtask

  initial begin
    logic [7:0] r;
    #40;
    checkEq("rst_miso", miso, 1'b0);
    checkEq("rst_power", power_ctl, 8'h00);
    checkEq("rst_filter", filter_ctl, 8'h13);
    checkEq("rst_xact", xact_done, 1'b0);
    resetn = 1'b1;
    #60;

    doRead(8'h00, 3);
    checkEq("id_ad", rxBuf[0], 8'hAD);
    checkEq("id_1d", rxBuf[1], 8'h1D);
    checkEq("id_part", rxBuf[2], 8'hF2);
    checkEq("xact_once", xactCnt, 1);

    x_data = 12'hF85;
    y_data = 12'h07A;
    doRead(8'h0E, 4);
    checkEq("xl", rxBuf[0], 8'h85);
    checkEq("xh", rxBuf[1], 8'hFF);
    checkEq("yl", rxBuf[2], 8'h7A);
    checkEq("yh", rxBuf[3], 8'h00);

    // x changes after the command byte; the snapshot must hold the old value.
    x_data = 12'h123;
    ssLow();
    spiByte(8'h0B, r);
    x_data = 12'h456;
    spiByte(8'h0E, r);
    spiByte(8'h00, r);
    checkEq("snap_l", r, 8'h23);
    spiByte(8'h00, r);
    checkEq("snap_h", r, 8'h01);
    ssHigh();

    doWrite(8'h2D, 8'h02);
    checkEq("wr_power", power_ctl, 8'h02);
    doWrite(8'h00, 8'h55);
    checkEq("wr_ro_power", power_ctl, 8'h02);
    checkEq("wr_ro_filter", filter_ctl, 8'h13);
    doWrite(8'h2C, 8'h11);
    checkEq("wr_filter", filter_ctl, 8'h11);
    doRead(8'h2C, 2);
    checkEq("rd_filter", rxBuf[0], 8'h11);
    checkEq("rd_power", rxBuf[1], 8'h02);

    doRead(8'hFF, 2);
    checkEq("wrap_ff", rxBuf[0], 8'h00);
    checkEq("wrap_00", rxBuf[1], 8'hAD);

    ssLow();
    spiByte(8'h0A, r);
    spiByte(8'h2D, r);
    spiBits(8'h77, 4, r);
    ssHigh();
    checkEq("partial_power", power_ctl, 8'h02);

    ssLow();
    spiByte(8'h0D, r);
    spiByte(8'h0E, r);
    checkEq("ign_b1", r, 8'h00);
    spiByte(8'h00, r);
    checkEq("ign_b2", r, 8'h00);
    checkEq("ign_miso", miso, 1'b0);
    ssHigh();

    doWrite(8'h1F, 8'h52);
`ifdef ACCEL_SOFT_RESET_EN
    checkEq("soft_power", power_ctl, 8'h00);
    checkEq("soft_filter", filter_ctl, 8'h13);
`else
    checkEq("nosoft_power", power_ctl, 8'h02);
    checkEq("nosoft_filter", filter_ctl, 8'h11);
`endif
    doRead(8'h1F, 1);
    checkEq("rd_1f", rxBuf[0], 8'h00);

    doWrite(8'h2D, 8'h02);
    checkEq("pre_rst_power", power_ctl, 8'h02);
    ssLow();
    spiByte(8'h0B, r);
    spiByte(8'h00, r);
    spiBits(8'h00, 4, r);
    checkEq("mid_bits", r, 8'hA0);
    resetn = 1'b0;
    #30;
    checkEq("midrst_miso", miso, 1'b0);
    checkEq("midrst_power", power_ctl, 8'h00);
    checkEq("midrst_filter", filter_ctl, 8'h13);
    resetn = 1'b1;
    #20;
    ssHigh();
    doRead(8'h02, 1);
    checkEq("post_rst_part", rxBuf[0], 8'hF2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
